score_display_scan: RTL and testbench

- Reader end of the 4-digit BCD score counter.
- Samples the four BCD digits (count1 = least significant, count4 = most significant) on an update strobe.
- Commits the new value only at a frame boundary, so the display never tears mid-frame.
- Time-multiplexes the digits onto a common-anode 4-digit seven-segment display, with a ghosting guard between digits and leading-zero blanking.

---
 rtl/score_display_scan.sv | 151 +++++++++++++++
 tb/tb_score_display_scan.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/score_display_scan.sv
// Four-digit BCD score display scanner: frame-boundary commit, ghosting guard, leading-zero blanking.
// Optional blink (16 frames on / 16 off) when SCORE_DISP_BLINK_EN is defined.
module score_display_scan #(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned GUARD_CYC   = 16,
   parameter int unsigned LZ_BLANK    = 1
) (
   input  logic       CLK,
   input  logic       RST,
`ifdef SCORE_DISP_BLINK_EN
   input  logic       Blink,
`endif
   input  logic       Upd,
   input  logic [3:0] count1,
   input  logic [3:0] count2,
   input  logic [3:0] count3,
   input  logic [3:0] count4,
   output logic [3:0] An,
   output logic [6:0] Seg,
   output logic       Pending
);

   localparam int unsigned CNT_W = 20;
   localparam int unsigned DIG_W = 2;
   localparam int unsigned SEG_W = 7;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD_CYC);
   localparam logic [SEG_W-1:0] SEG_OFF   = 7'b1111111;

   // State encoding is {digit, on}: even = GUARD, odd = ON.
   typedef enum logic [2:0] {
      S_G0 = 3'd0, S_O0 = 3'd1, S_G1 = 3'd2, S_O1 = 3'd3,
      S_G2 = 3'd4, S_O2 = 3'd5, S_G3 = 3'd6, S_O3 = 3'd7
   } state_e;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [DIG_W-1:0]       dig_q, dig_d;
   logic [3:0][3:0]        shadow_q, disp_q;
   logic                   pending_q;
   logic [3:0]             an_q, an_d;
   logic [SEG_W-1:0]       seg_q, seg_d;
   logic                   boundary_c, dark_c;
   logic                   z3_c, z2_c, z1_c;
   logic [3:0]             blank_c;
   logic [2:0]             st_bits_c;
   logic [DIG_W-1:0]       sel_dig_c;
   logic [3:0][3:0]        counts_c;

   assign counts_c   = {count4, count3, count2, count1};
   assign boundary_c = (cnt_q == CNT_LAST) && (dig_q == 2'd3);

   function automatic logic [SEG_W-1:0] decode(input logic [3:0] v);
      case (v)
         4'd0:    decode = 7'b1000000;
         4'd1:    decode = 7'b1111001;
         4'd2:    decode = 7'b0100100;
         4'd3:    decode = 7'b0110000;
         4'd4:    decode = 7'b0011001;
         4'd5:    decode = 7'b0010010;
         4'd6:    decode = 7'b0000010;
         4'd7:    decode = 7'b1111000;
         4'd8:    decode = 7'b0000000;
         4'd9:    decode = 7'b0010000;
         default: decode = 7'b0111111;
      endcase
   endfunction

`ifdef SCORE_DISP_BLINK_EN
   logic [4:0] frame_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)             frame_q <= '0;
      else if (boundary_c) frame_q <= frame_q + 5'd1;
   end

   assign dark_c = Blink && frame_q[4];
`else
   assign dark_c = 1'b0;
`endif

   // Blanking walks down from the most significant digit; any non-zero (incl. invalid) stops it.
   always_comb begin
      z3_c    = (LZ_BLANK != 0) && (disp_q[3] == 4'd0);
      z2_c    = z3_c && (disp_q[2] == 4'd0);
      z1_c    = z2_c && (disp_q[1] == 4'd0);
      blank_c = {z3_c, z2_c, z1_c, 1'b0};
   end

   // Next scan position and the phase state it implies.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      dig_d = dig_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         dig_d = dig_q + DIG_W'(1);
      end
      state_d = state_e'({dig_d, (cnt_d >= CNT_GUARD)});
   end

   // Output decode from the current phase; registered below so An and Seg move together.
   always_comb begin
      an_d      = 4'b1111;
      seg_d     = SEG_OFF;
      st_bits_c = state_q;
      sel_dig_c = st_bits_c[2:1];
      if (st_bits_c[0] && !blank_c[sel_dig_c] && !dark_c) begin
         an_d  = ~(4'b0001 << sel_dig_c);
         seg_d = decode(disp_q[sel_dig_c]);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_G0;
         cnt_q   <= '0;
         dig_q   <= '0;
         an_q    <= 4'b1111;
         seg_q   <= SEG_OFF;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dig_q   <= dig_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

   // Capture into shadow; commit only at the frame boundary to avoid tearing.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         shadow_q  <= '0;
         disp_q    <= '0;
         pending_q <= 1'b0;
      end else begin
         if (Upd) shadow_q <= counts_c;
         if (boundary_c) begin
            if (Upd)            disp_q <= counts_c;
            else if (pending_q) disp_q <= shadow_q;
            pending_q <= 1'b0;
         end else if (Upd) begin
            pending_q <= 1'b1;
         end
      end
   end

   assign An      = an_q;
   assign Seg     = seg_q;
   assign Pending = pending_q;

endmodule

// File: tb/tb_score_display_scan.sv
// Directed bench for score_display_scan (REFRESH_DIV=8, GUARD_CYC=2, LZ_BLANK=1).
module tb_score_display_scan;

   logic       CLK, RST, Upd;
   logic [3:0] count1, count2, count3, count4;
   logic [3:0] An;
   logic [6:0] Seg;
   logic       Pending;
`ifdef SCORE_DISP_BLINK_EN
   logic       Blink;
`endif

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;
   int unsigned k      = 0;
   logic [6:0]  exp_seg [4];
   logic [3:0]  exp_blank;
   logic        exp_dark;

   score_display_scan #(.REFRESH_DIV(8), .GUARD_CYC(2), .LZ_BLANK(1)) dut (
      .CLK(CLK), .RST(RST),
`ifdef SCORE_DISP_BLINK_EN
      .Blink(Blink),
`endif
      .Upd(Upd), .count1(count1), .count2(count2), .count3(count3), .count4(count4),
      .An(An), .Seg(Seg), .Pending(Pending)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk4(input string tag, input logic [3:0] got, input logic [3:0] want);
      n_cmp++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s k=%0d got %b want %b", tag, k, got, want);
      end
   endtask

   task automatic chk7(input string tag, input logic [6:0] got, input logic [6:0] want);
      n_cmp++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s k=%0d got %b want %b", tag, k, got, want);
      end
   endtask

   task automatic chk1(input string tag, input logic got, input logic want);
      n_cmp++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s k=%0d got %b want %b", tag, k, got, want);
      end
   endtask

   // One clock; outputs after tick k show scan position k-1 (one-cycle registered latency).
   task automatic tick_chk();
      int p, c, d;
      logic [3:0] ea;
      logic [6:0] es;
      @(posedge CLK);
      @(negedge CLK);
      k++;
      p = (k - 1) % 32;
      c = p % 8;
      d = p / 8;
`ifdef SCORE_DISP_BLINK_EN
      exp_dark = Blink && ((((k - 1) / 32) % 32) >= 16);
`else
      exp_dark = 1'b0;
`endif
      ea = 4'b1111;
      es = 7'b1111111;
      if (c >= 2 && !exp_blank[d] && !exp_dark) begin
         ea = 4'b1111;
         ea[d] = 1'b0;
         es = exp_seg[d];
      end
      chk4("an", An, ea);
      chk7("seg", Seg, es);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick_chk();
   endtask

   task automatic pulse(input logic [3:0] c4, input logic [3:0] c3, input logic [3:0] c2,
                        input logic [3:0] c1);
      count4 = c4; count3 = c3; count2 = c2; count1 = c1;
      Upd = 1'b1;
      tick_chk();
      Upd = 1'b0;
   endtask

   task automatic set_exp(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                          input logic [6:0] s0, input logic [3:0] bl);
      exp_seg[3] = s3; exp_seg[2] = s2; exp_seg[1] = s1; exp_seg[0] = s0;
      exp_blank = bl;
   endtask

   initial begin
      RST = 1'b1; Upd = 1'b0;
      count1 = '0; count2 = '0; count3 = '0; count4 = '0;
`ifdef SCORE_DISP_BLINK_EN
      Blink = 1'b0;
`endif
      @(negedge CLK); @(negedge CLK);
      chk4("rst_an", An, 4'b1111);
      chk7("rst_seg", Seg, 7'b1111111);
      chk1("rst_pend", Pending, 1'b0);
      RST = 1'b0; k = 0;

      // Power-up: only digit 0 shows "0".
      set_exp(7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 4'b1110);
      run(16);
      pulse(4'd1, 4'd2, 4'd3, 4'd4);
      chk1("pend_set", Pending, 1'b1);
      run(15);
      chk1("pend_clr", Pending, 1'b0);

      set_exp(7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 4'b0000);
      run(16);
      pulse(4'd0, 4'd0, 4'd5, 4'd0);
      run(15);

      set_exp(7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000, 4'b1100);
      run(16);
      pulse(4'd0, 4'hC, 4'd0, 4'd0);
      run(15);

      // Invalid digit 2 stops blanking below it.
      set_exp(7'b1000000, 7'b0111111, 7'b1000000, 7'b1000000, 4'b1000);
      run(8);
      pulse(4'd1, 4'd1, 4'd1, 4'd1);
      run(8);
      pulse(4'd2, 4'd2, 4'd2, 4'd2);
      chk1("pend_two", Pending, 1'b1);
      run(14);

      // Last capture wins; then an Upd exactly on the boundary edge.
      set_exp(7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100, 4'b0000);
      run(31);
      pulse(4'd3, 4'd3, 4'd3, 4'd3);
      chk1("pend_bnd", Pending, 1'b0);

      set_exp(7'b0110000, 7'b0110000, 7'b0110000, 7'b0110000, 4'b0000);
      run(21);
      chk4("an_dig2", An, 4'b1011);
      RST = 1'b1;
      #1;
      chk4("arst_an", An, 4'b1111);
      chk7("arst_seg", Seg, 7'b1111111);
      chk1("arst_pend", Pending, 1'b0);
      @(negedge CLK); @(negedge CLK);
      RST = 1'b0; k = 0;

      set_exp(7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 4'b1110);
      run(32);
`ifdef SCORE_DISP_BLINK_EN
      Blink = 1'b1;
      run(32 * 17);
      Blink = 1'b0;
      run(32);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
